// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA multi-core controller: opcodes,
// command word field positions and the controller state encoding.
package rsa_pkg;

    // Command opcodes (command word bits [3:0])
    localparam logic [3:0] CMD_COMPUTE_EXP  = 4'd0;
    localparam logic [3:0] CMD_COMPUTE_MONT = 4'd1;
    localparam logic [3:0] CMD_READ_MOD     = 4'd2;
    localparam logic [3:0] CMD_READ_RSQ     = 4'd3;
    localparam logic [3:0] CMD_READ_EXP     = 4'd4;
    localparam logic [3:0] CMD_WRITE        = 4'd5;

    // Command word field positions
    localparam int OPC_LSB    = 0;
    localparam int OPC_MSB    = 3;
    localparam int IDX_LSB    = 8;
    localparam int NOWAIT_BIT = 16;

    // Controller states, visible on leds[2:0]
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RX       = 3'd1,
        ST_START    = 3'd2,
        ST_WAITCORE = 3'd3,
        ST_TX       = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

    // True for the three operand-load opcodes
    function automatic logic opc_is_read(input logic [3:0] opc);
        return (opc == CMD_READ_MOD) || (opc == CMD_READ_RSQ) || (opc == CMD_READ_EXP);
    endfunction

    // True for the two launch opcodes
    function automatic logic opc_is_compute(input logic [3:0] opc);
        return (opc == CMD_COMPUTE_EXP) || (opc == CMD_COMPUTE_MONT);
    endfunction

endpackage

// File: rtl/rsa_core_slot.sv
// Per-core state: operand registers (modulus, RSQ/A, EXP/B), launch mode,
// and the busy / result-valid flags that track the core independently of
// the controller FSM so that no done pulse is ever missed.
module rsa_core_slot
    import rsa_pkg::*;
#(
    parameter int DATA_W = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en_i,
    input  logic [3:0]        wr_opc_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              launch_i,
    input  logic              mode_i,
    input  logic              done_i,
    output logic [DATA_W-1:0] mod_o,
    output logic [DATA_W-1:0] op_a_o,
    output logic [DATA_W-1:0] op_b_o,
    output logic              mode_o,
    output logic              busy_o,
    output logic              res_valid_o
);

    logic [DATA_W-1:0] mod_q, mod_d;
    logic [DATA_W-1:0] op_a_q, op_a_d;
    logic [DATA_W-1:0] op_b_q, op_b_d;
    logic              mode_q, mode_d;
    logic              busy_q, busy_d;
    logic              res_valid_q, res_valid_d;

    // Operand load: the opcode selects which register takes the data word
    always_comb begin
        mod_d  = mod_q;
        op_a_d = op_a_q;
        op_b_d = op_b_q;
        if (wr_en_i) begin
            case (wr_opc_i)
                CMD_READ_MOD: mod_d  = wr_data_i;
                CMD_READ_RSQ: op_a_d = wr_data_i;
                CMD_READ_EXP: op_b_d = wr_data_i;
                default: ;
            endcase
        end
    end

    // Flag update: a done pulse retires the run; a launch overrides it
    always_comb begin
        mode_d      = mode_q;
        busy_d      = busy_q;
        res_valid_d = res_valid_q;
        if (done_i) begin
            busy_d      = 1'b0;
            res_valid_d = 1'b1;
        end
        if (launch_i) begin
            busy_d      = 1'b1;
            res_valid_d = 1'b0;
            mode_d      = mode_i;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mod_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            mode_q      <= 1'b0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            mod_q       <= mod_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            mode_q      <= mode_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign mod_o       = mod_q;
    assign op_a_o      = op_a_q;
    assign op_b_o      = op_b_q;
    assign mode_o      = mode_q;
    assign busy_o      = busy_q;
    assign res_valid_o = res_valid_q;

endmodule

// File: rtl/rsa_multicore_ctrl.sv
// Command/data front-end for NUM_CORES RSA cores. Decodes ARM commands,
// loads per-core operands, launches cores (blocking or non-blocking) and
// returns results.
// Handshakes: a data word moves on a rising clock edge where both valid and
// ready are high; the sender holds data stable while valid is high and ready
// is low. fpga_to_arm_done stays high until done_read is sampled high.
module rsa_multicore_ctrl
    import rsa_pkg::*;
#(
    parameter int DATA_W    = 1024,
    parameter int NUM_CORES = 2,
    parameter int IDX_W     = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [31:0]                   arm_to_fpga_cmd,
    input  logic                          arm_to_fpga_cmd_valid,
    output logic                          fpga_to_arm_done,
    input  logic                          fpga_to_arm_done_read,
    input  logic                          arm_to_fpga_data_valid,
    output logic                          arm_to_fpga_data_ready,
    input  logic [DATA_W-1:0]             arm_to_fpga_data,
    output logic                          fpga_to_arm_data_valid,
    input  logic                          fpga_to_arm_data_ready,
    output logic [DATA_W-1:0]             fpga_to_arm_data,
    output logic                          cmd_error,
    output logic [NUM_CORES-1:0]          core_start,
    output logic [NUM_CORES-1:0]          core_mode,
    output logic [NUM_CORES*DATA_W-1:0]   core_mod,
    output logic [NUM_CORES*DATA_W-1:0]   core_op_a,
    output logic [NUM_CORES*DATA_W-1:0]   core_op_b,
    input  logic [NUM_CORES*DATA_W-1:0]   core_result,
    input  logic [NUM_CORES-1:0]          core_done,
    output logic [3:0]                    leds
);

    localparam logic [IDX_W:0] NUM_CORES_W = (IDX_W+1)'(NUM_CORES);

    state_e             state_q, state_d;
    logic [3:0]         opc_q, opc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               nowait_q, nowait_d;
    logic               cmd_error_q, cmd_error_d;
    logic [DATA_W-1:0]  tx_data_q, tx_data_d;

    logic [3:0]         cmd_opc;
    logic [IDX_W-1:0]   cmd_idx;
    logic               cmd_nowait;
    logic               cmd_legal;
    logic               launch;
    logic               unused_cmd;

    logic [NUM_CORES-1:0] core_wr;
    logic [NUM_CORES-1:0] busy;
    logic [NUM_CORES-1:0] res_valid;
    logic                 sel_busy;
    logic                 sel_res_valid;
    logic [DATA_W-1:0]    sel_result;

    assign cmd_opc    = arm_to_fpga_cmd[OPC_MSB:OPC_LSB];
    assign cmd_idx    = arm_to_fpga_cmd[IDX_LSB +: IDX_W];
    assign cmd_nowait = arm_to_fpga_cmd[NOWAIT_BIT];
    assign cmd_legal  = (cmd_opc <= CMD_WRITE) && ({1'b0, cmd_idx} < NUM_CORES_W);
    assign unused_cmd = ^arm_to_fpga_cmd;

    // Per-core slots
    for (genvar g = 0; g < NUM_CORES; g++) begin : g_slot
        rsa_core_slot #(.DATA_W(DATA_W)) u_slot (
            .clk         (clk),
            .reset       (reset),
            .wr_en_i     (core_wr[g]),
            .wr_opc_i    (opc_q),
            .wr_data_i   (arm_to_fpga_data),
            .launch_i    (core_start[g]),
            .mode_i      (opc_q == CMD_COMPUTE_MONT),
            .done_i      (core_done[g]),
            .mod_o       (core_mod[g*DATA_W +: DATA_W]),
            .op_a_o      (core_op_a[g*DATA_W +: DATA_W]),
            .op_b_o      (core_op_b[g*DATA_W +: DATA_W]),
            .mode_o      (core_mode[g]),
            .busy_o      (busy[g]),
            .res_valid_o (res_valid[g])
        );
    end

    // Index-driven muxes: flags and result of the latched core index
    always_comb begin
        sel_busy      = 1'b0;
        sel_res_valid = 1'b0;
        sel_result    = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_busy      = busy[i];
                sel_res_valid = res_valid[i];
                sel_result    = core_result[i*DATA_W +: DATA_W];
            end
        end
    end

    // Index-driven demux: start pulse and operand write strobe per core
    always_comb begin
        core_start = '0;
        core_wr    = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            core_start[i] = launch && (idx_q == IDX_W'(i));
            core_wr[i]    = (state_q == ST_RX) && arm_to_fpga_data_valid && (idx_q == IDX_W'(i));
        end
    end

    // FSM next state and handshake outputs
    always_comb begin
        state_d                = state_q;
        opc_d                  = opc_q;
        idx_d                  = idx_q;
        nowait_d               = nowait_q;
        cmd_error_d            = cmd_error_q;
        tx_data_d              = tx_data_q;
        launch                 = 1'b0;
        arm_to_fpga_data_ready = 1'b0;
        fpga_to_arm_data_valid = 1'b0;
        fpga_to_arm_done       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arm_to_fpga_cmd_valid) begin
                    opc_d    = cmd_opc;
                    idx_d    = cmd_idx;
                    nowait_d = cmd_nowait;
                    if (!cmd_legal) begin
                        cmd_error_d = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        cmd_error_d = 1'b0;
                        if (opc_is_read(cmd_opc))         state_d = ST_RX;
                        else if (opc_is_compute(cmd_opc)) state_d = ST_START;
                        else                              state_d = ST_WAITCORE;
                    end
                end
            end
            ST_RX: begin
                arm_to_fpga_data_ready = 1'b1;
                if (arm_to_fpga_data_valid) state_d = ST_DONE;
            end
            ST_START: begin
                // Hold off until the previous run on this core has finished
                if (!sel_busy) begin
                    launch  = 1'b1;
                    state_d = nowait_q ? ST_DONE : ST_WAITCORE;
                end
            end
            ST_WAITCORE: begin
                if (opc_q == CMD_WRITE) begin
                    // Not busy covers both a finished run and a never-launched core
                    if (!sel_busy) begin
                        tx_data_d = sel_result;
                        state_d   = ST_TX;
                    end
                end else if (sel_res_valid) begin
                    state_d = ST_DONE;
                end
            end
            ST_TX: begin
                fpga_to_arm_data_valid = 1'b1;
                if (fpga_to_arm_data_ready) state_d = ST_DONE;
            end
            ST_DONE: begin
                fpga_to_arm_done = 1'b1;
                if (fpga_to_arm_done_read) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and command registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            opc_q       <= '0;
            idx_q       <= '0;
            nowait_q    <= 1'b0;
            cmd_error_q <= 1'b0;
            tx_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            opc_q       <= opc_d;
            idx_q       <= idx_d;
            nowait_q    <= nowait_d;
            cmd_error_q <= cmd_error_d;
            tx_data_q   <= tx_data_d;
        end
    end

    assign fpga_to_arm_data = tx_data_q;
    assign cmd_error        = cmd_error_q;
    assign leds             = {cmd_error_q, state_q};

endmodule

// File: tb/tb_rsa_multicore_ctrl.sv
// Bench for rsa_multicore_ctrl: drives ARM commands and fake core
// done/result traffic, and compares against a simple operand model.
module tb_rsa_multicore_ctrl;

    localparam int DATA_W    = 1024;
    localparam int NUM_CORES = 2;
    localparam int IDX_W     = 4;

    localparam logic [3:0] OP_EXP   = 4'd0;
    localparam logic [3:0] OP_MONT  = 4'd1;
    localparam logic [3:0] OP_MOD   = 4'd2;
    localparam logic [3:0] OP_RSQ   = 4'd3;
    localparam logic [3:0] OP_EXPB  = 4'd4;
    localparam logic [3:0] OP_WRITE = 4'd5;

    logic                        clk;
    logic                        reset;
    logic [31:0]                 arm_to_fpga_cmd;
    logic                        arm_to_fpga_cmd_valid;
    logic                        fpga_to_arm_done;
    logic                        fpga_to_arm_done_read;
    logic                        arm_to_fpga_data_valid;
    logic                        arm_to_fpga_data_ready;
    logic [DATA_W-1:0]           arm_to_fpga_data;
    logic                        fpga_to_arm_data_valid;
    logic                        fpga_to_arm_data_ready;
    logic [DATA_W-1:0]           fpga_to_arm_data;
    logic                        cmd_error;
    logic [NUM_CORES-1:0]        core_start;
    logic [NUM_CORES-1:0]        core_mode;
    logic [NUM_CORES*DATA_W-1:0] core_mod;
    logic [NUM_CORES*DATA_W-1:0] core_op_a;
    logic [NUM_CORES*DATA_W-1:0] core_op_b;
    logic [NUM_CORES*DATA_W-1:0] core_result;
    logic [NUM_CORES-1:0]        core_done;
    logic [3:0]                  leds;

    rsa_multicore_ctrl #(.DATA_W(DATA_W), .NUM_CORES(NUM_CORES), .IDX_W(IDX_W)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .arm_to_fpga_cmd        (arm_to_fpga_cmd),
        .arm_to_fpga_cmd_valid  (arm_to_fpga_cmd_valid),
        .fpga_to_arm_done       (fpga_to_arm_done),
        .fpga_to_arm_done_read  (fpga_to_arm_done_read),
        .arm_to_fpga_data_valid (arm_to_fpga_data_valid),
        .arm_to_fpga_data_ready (arm_to_fpga_data_ready),
        .arm_to_fpga_data       (arm_to_fpga_data),
        .fpga_to_arm_data_valid (fpga_to_arm_data_valid),
        .fpga_to_arm_data_ready (fpga_to_arm_data_ready),
        .fpga_to_arm_data       (fpga_to_arm_data),
        .cmd_error              (cmd_error),
        .core_start             (core_start),
        .core_mode              (core_mode),
        .core_mod               (core_mod),
        .core_op_a              (core_op_a),
        .core_op_b              (core_op_b),
        .core_result            (core_result),
        .core_done              (core_done),
        .leds                   (leds)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // ---------------- counters and model ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int start_cnt[NUM_CORES];

    logic [DATA_W-1:0] m_mod [NUM_CORES];
    logic [DATA_W-1:0] m_a   [NUM_CORES];
    logic [DATA_W-1:0] m_b   [NUM_CORES];

    // Count core_start pulses per core, sampled away from the active edge
    always @(negedge clk) begin
        for (int i = 0; i < NUM_CORES; i++)
            if (core_start[i] === 1'b1) start_cnt[i]++;
    end

    function automatic logic [DATA_W-1:0] rand_word();
        logic [DATA_W-1:0] w;
        for (int k = 0; k < DATA_W/32; k++) w[k*32 +: 32] = $urandom();
        return w;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NUM_CORES; i++) begin
            m_mod[i] = '0;
            m_a[i]   = '0;
            m_b[i]   = '0;
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input logic [3:0] opc, input int idx, input bit nowait);
        logic [3:0] ix;
        ix = 4'(idx);
        arm_to_fpga_cmd       = {15'd0, nowait, 4'd0, ix, 4'd0, opc};
        arm_to_fpga_cmd_valid = 1'b1;
        tick();
        arm_to_fpga_cmd_valid = 1'b0;
        arm_to_fpga_cmd       = '0;
    endtask

    task automatic do_rx(input logic [DATA_W-1:0] w, output bit ok, output bit done_next);
        int k;
        k = 0;
        while (arm_to_fpga_data_ready !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        ok = (arm_to_fpga_data_ready === 1'b1);
        arm_to_fpga_data       = w;
        arm_to_fpga_data_valid = 1'b1;
        tick();
        arm_to_fpga_data_valid = 1'b0;
        done_next = (fpga_to_arm_done === 1'b1);
    endtask

    task automatic wait_done(output bit ok);
        int k;
        k = 0;
        while (fpga_to_arm_done !== 1'b1 && k < 60) begin
            tick();
            k++;
        end
        ok = (fpga_to_arm_done === 1'b1);
    endtask

    task automatic ack_done();
        fpga_to_arm_done_read = 1'b1;
        tick();
        fpga_to_arm_done_read = 1'b0;
    endtask

    task automatic wait_tx_valid(output bit ok);
        int k;
        k = 0;
        while (fpga_to_arm_data_valid !== 1'b1 && k < 60) begin
            tick();
            k++;
        end
        ok = (fpga_to_arm_data_valid === 1'b1);
    endtask

    task automatic do_tx(output logic [DATA_W-1:0] w, output bit ok);
        wait_tx_valid(ok);
        w = fpga_to_arm_data;
        fpga_to_arm_data_ready = 1'b1;
        tick();
        fpga_to_arm_data_ready = 1'b0;
    endtask

    task automatic fire_done(input logic [NUM_CORES-1:0] m);
        core_done = m;
        tick();
        core_done = '0;
    endtask

    // Full operand load; the model records what the register should now hold
    task automatic load_reg(input logic [3:0] opc, input int c, input logic [DATA_W-1:0] w,
                            output bit ok, output bit done_next);
        bit ok_rx, ok_dn;
        do_cmd(opc, c, 1'b0);
        do_rx(w, ok_rx, done_next);
        wait_done(ok_dn);
        ack_done();
        ok = ok_rx && ok_dn;
        case (opc)
            OP_MOD:  m_mod[c] = w;
            OP_RSQ:  m_a[c]   = w;
            OP_EXPB: m_b[c]   = w;
            default: ;
        endcase
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_checks++; if (fpga_to_arm_done !== 1'b0) $display("FAIL reset_done: got %b exp 0", fpga_to_arm_done); else n_pass++;
        n_checks++; if (arm_to_fpga_data_ready !== 1'b0) $display("FAIL reset_ready: got %b exp 0", arm_to_fpga_data_ready); else n_pass++;
        n_checks++; if (fpga_to_arm_data_valid !== 1'b0) $display("FAIL reset_out_valid: got %b exp 0", fpga_to_arm_data_valid); else n_pass++;
        n_checks++; if (fpga_to_arm_data !== '0) $display("FAIL reset_out_data: set bits %0d exp 0", $countones(fpga_to_arm_data)); else n_pass++;
        n_checks++; if (cmd_error !== 1'b0) $display("FAIL reset_cmd_error: got %b exp 0", cmd_error); else n_pass++;
        n_checks++; if (core_start !== '0) $display("FAIL reset_core_start: got %b exp 0", core_start); else n_pass++;
        n_checks++; if (core_mode !== '0) $display("FAIL reset_core_mode: got %b exp 0", core_mode); else n_pass++;
        n_checks++; if (leds !== 4'h0) $display("FAIL reset_leds: got %h exp 0", leds); else n_pass++;
        n_checks++; if (core_mod !== '0) $display("FAIL reset_core_mod: set bits %0d exp 0", $countones(core_mod)); else n_pass++;
        n_checks++; if (core_op_a !== '0) $display("FAIL reset_core_op_a: set bits %0d exp 0", $countones(core_op_a)); else n_pass++;
        n_checks++; if (core_op_b !== '0) $display("FAIL reset_core_op_b: set bits %0d exp 0", $countones(core_op_b)); else n_pass++;
    endtask

    task automatic test_mont_blocking();
        logic [DATA_W-1:0] res, got;
        bit ok, dn;
        int s0;
        load_reg(OP_RSQ, 0, rand_word(), ok, dn);
        n_checks++; if (!(ok && dn)) $display("FAIL mont_load_rsq: ok=%b done_next=%b exp 1 1", ok, dn); else n_pass++;
        load_reg(OP_MOD, 0, rand_word(), ok, dn);
        n_checks++; if (!(ok && dn)) $display("FAIL mont_load_mod: ok=%b done_next=%b exp 1 1", ok, dn); else n_pass++;
        load_reg(OP_EXPB, 0, rand_word(), ok, dn);
        n_checks++; if (!(ok && dn)) $display("FAIL mont_load_b: ok=%b done_next=%b exp 1 1", ok, dn); else n_pass++;
        n_checks++; if (core_mod[0 +: DATA_W] !== m_mod[0]) $display("FAIL mont_mod0: got %h exp %h (low 64)", core_mod[63:0], m_mod[0][63:0]); else n_pass++;
        n_checks++; if (core_op_a[0 +: DATA_W] !== m_a[0]) $display("FAIL mont_a0: got %h exp %h (low 64)", core_op_a[63:0], m_a[0][63:0]); else n_pass++;
        n_checks++; if (core_op_b[0 +: DATA_W] !== m_b[0]) $display("FAIL mont_b0: got %h exp %h (low 64)", core_op_b[63:0], m_b[0][63:0]); else n_pass++;

        s0 = start_cnt[0];
        do_cmd(OP_MONT, 0, 1'b0);
        repeat (4) tick();
        n_checks++; if (start_cnt[0] !== s0 + 1) $display("FAIL mont_start_pulses: got %0d exp %0d", start_cnt[0] - s0, 1); else n_pass++;
        n_checks++; if (core_mode[0] !== 1'b1) $display("FAIL mont_mode: got %b exp 1", core_mode[0]); else n_pass++;
        n_checks++; if (fpga_to_arm_done !== 1'b0) $display("FAIL mont_blocking_done_early: got %b exp 0", fpga_to_arm_done); else n_pass++;

        res = rand_word();
        core_result[0 +: DATA_W] = res;
        fire_done(2'b01);
        wait_done(ok);
        n_checks++; if (!ok) $display("FAIL mont_done_timeout: done=%b exp 1", fpga_to_arm_done); else n_pass++;
        ack_done();

        do_cmd(OP_WRITE, 0, 1'b0);
        do_tx(got, ok);
        n_checks++; if (!ok || got !== res) $display("FAIL mont_write_result: ok=%b got %h exp %h (low 64)", ok, got[63:0], res[63:0]); else n_pass++;
        wait_done(ok);
        n_checks++; if (!ok) $display("FAIL mont_write_done: done=%b exp 1", fpga_to_arm_done); else n_pass++;
        ack_done();
        n_checks++; if (fpga_to_arm_done !== 1'b0) $display("FAIL mont_done_falls: got %b exp 0", fpga_to_arm_done); else n_pass++;
    endtask

    task automatic test_nowait_concurrent();
        logic [DATA_W-1:0] r0, r1, got, e;
        bit ok, dn;
        int s;
        e = '0;
        e[7:0] = 8'haf;
        for (int c = 0; c < NUM_CORES; c++) begin
            load_reg(OP_EXPB, c, e, ok, dn);
            load_reg(OP_MOD, c, rand_word(), ok, dn);
            load_reg(OP_RSQ, c, rand_word(), ok, dn);
            n_checks++; if (core_op_b[c*DATA_W +: DATA_W] !== m_b[c] || core_mod[c*DATA_W +: DATA_W] !== m_mod[c])
                $display("FAIL nowait_load_core%0d: b %h exp %h (low 64)", c, core_op_b[c*DATA_W +: 64], m_b[c][63:0]); else n_pass++;
        end
        for (int c = 0; c < NUM_CORES; c++) begin
            s = start_cnt[c];
            do_cmd(OP_EXP, c, 1'b1);
            n_checks++; if (fpga_to_arm_done !== 1'b0) $display("FAIL nowait_done_1cyc_core%0d: got %b exp 0", c, fpga_to_arm_done); else n_pass++;
            tick();
            n_checks++; if (fpga_to_arm_done !== 1'b1) $display("FAIL nowait_done_2cyc_core%0d: got %b exp 1", c, fpga_to_arm_done); else n_pass++;
            ack_done();
            n_checks++; if (start_cnt[c] !== s + 1) $display("FAIL nowait_start_core%0d: got %0d exp 1", c, start_cnt[c] - s); else n_pass++;
            n_checks++; if (core_mode[c] !== 1'b0) $display("FAIL nowait_mode_core%0d: got %b exp 0", c, core_mode[c]); else n_pass++;
        end
        r0 = rand_word();
        r1 = rand_word();
        core_result = {r1, r0};
        fire_done(2'b11);
        repeat (2) tick();

        do_cmd(OP_WRITE, 1, 1'b0);
        do_tx(got, ok);
        n_checks++; if (!ok || got !== r1) $display("FAIL nowait_write_core1: ok=%b got %h exp %h (low 64)", ok, got[63:0], r1[63:0]); else n_pass++;
        wait_done(ok);
        ack_done();
        do_cmd(OP_WRITE, 0, 1'b0);
        do_tx(got, ok);
        n_checks++; if (!ok || got !== r0) $display("FAIL nowait_write_core0: ok=%b got %h exp %h (low 64)", ok, got[63:0], r0[63:0]); else n_pass++;
        wait_done(ok);
        ack_done();
    endtask

    task automatic test_illegal();
        logic [DATA_W-1:0] w;
        bit ok, dn;
        int s0, s1;
        s0 = start_cnt[0];
        s1 = start_cnt[1];
        do_cmd(4'd7, 1, 1'b0);
        n_checks++; if (cmd_error !== 1'b1) $display("FAIL illegal_opc_error: got %b exp 1", cmd_error); else n_pass++;
        n_checks++; if (leds[3] !== 1'b1) $display("FAIL illegal_opc_led: got %b exp 1", leds[3]); else n_pass++;
        n_checks++; if (fpga_to_arm_done !== 1'b1) $display("FAIL illegal_opc_done: got %b exp 1", fpga_to_arm_done); else n_pass++;
        ack_done();
        do_cmd(OP_EXP, NUM_CORES, 1'b0);
        n_checks++; if (cmd_error !== 1'b1 || fpga_to_arm_done !== 1'b1) $display("FAIL illegal_idx: error=%b done=%b exp 1 1", cmd_error, fpga_to_arm_done); else n_pass++;
        ack_done();
        repeat (2) tick();
        n_checks++; if (start_cnt[0] !== s0 || start_cnt[1] !== s1) $display("FAIL illegal_no_start: got %0d,%0d exp 0,0", start_cnt[0] - s0, start_cnt[1] - s1); else n_pass++;

        w = rand_word();
        do_cmd(OP_EXPB, 1, 1'b0);
        n_checks++; if (cmd_error !== 1'b0) $display("FAIL illegal_cleared: got %b exp 0", cmd_error); else n_pass++;
        do_rx(w, ok, dn);
        m_b[1] = w;
        wait_done(ok);
        ack_done();
        n_checks++; if (core_op_b[DATA_W +: DATA_W] !== m_b[1]) $display("FAIL illegal_then_load: got %h exp %h (low 64)", core_op_b[DATA_W +: 64], m_b[1][63:0]); else n_pass++;
    endtask

    task automatic test_write_waits();
        logic [DATA_W-1:0] r, got;
        bit ok;
        do_cmd(OP_EXP, 0, 1'b1);
        wait_done(ok);
        ack_done();
        do_cmd(OP_WRITE, 0, 1'b0);
        repeat (5) tick();
        n_checks++; if (fpga_to_arm_data_valid !== 1'b0 || fpga_to_arm_done !== 1'b0)
            $display("FAIL wait_no_early_valid: valid=%b done=%b exp 0 0", fpga_to_arm_data_valid, fpga_to_arm_done); else n_pass++;
        r = rand_word();
        core_result[0 +: DATA_W] = r;
        fire_done(2'b01);
        wait_tx_valid(ok);
        n_checks++; if (!ok) $display("FAIL wait_valid_timeout: valid=%b exp 1", fpga_to_arm_data_valid); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (fpga_to_arm_data_valid !== 1'b1 || fpga_to_arm_data !== r)
                $display("FAIL wait_hold_%0d: valid=%b data %h exp 1 %h (low 64)", k, fpga_to_arm_data_valid, fpga_to_arm_data[63:0], r[63:0]); else n_pass++;
        end
        do_tx(got, ok);
        n_checks++; if (!ok || got !== r) $display("FAIL wait_tx_data: got %h exp %h (low 64)", got[63:0], r[63:0]); else n_pass++;
        wait_done(ok);
        n_checks++; if (!ok || fpga_to_arm_data_valid !== 1'b0) $display("FAIL wait_tx_done: done=%b valid=%b exp 1 0", fpga_to_arm_done, fpga_to_arm_data_valid); else n_pass++;
        ack_done();
    endtask

    task automatic test_busy_start();
        logic [DATA_W-1:0] r;
        bit ok;
        int s;
        do_cmd(OP_MONT, 1, 1'b1);
        wait_done(ok);
        ack_done();
        s = start_cnt[1];
        do_cmd(OP_EXP, 1, 1'b0);
        repeat (4) tick();
        n_checks++; if (start_cnt[1] !== s) $display("FAIL busy_no_double_start: got %0d exp 0", start_cnt[1] - s); else n_pass++;
        n_checks++; if (fpga_to_arm_done !== 1'b0) $display("FAIL busy_done_early: got %b exp 0", fpga_to_arm_done); else n_pass++;
        core_done = 2'b10;
        tick();
        core_done = '0;
        n_checks++; if (core_start !== 2'b10) $display("FAIL busy_start_after_done: got %b exp 10", core_start); else n_pass++;
        tick();
        n_checks++; if (start_cnt[1] !== s + 1 || core_mode[1] !== 1'b0) $display("FAIL busy_relaunch: starts %0d mode %b exp 1 0", start_cnt[1] - s, core_mode[1]); else n_pass++;
        r = rand_word();
        core_result[DATA_W +: DATA_W] = r;
        fire_done(2'b10);
        wait_done(ok);
        n_checks++; if (!ok) $display("FAIL busy_blocking_done: done=%b exp 1", fpga_to_arm_done); else n_pass++;
        ack_done();
    endtask

    task automatic test_back_to_back();
        logic [3:0] opc;
        bit ok, dn;
        int c;
        for (int n = 0; n < 8; n++) begin
            c   = $urandom_range(0, NUM_CORES - 1);
            opc = OP_MOD + 4'($urandom_range(0, 2));
            load_reg(opc, c, rand_word(), ok, dn);
            n_checks++; if (!(ok && dn)) $display("FAIL b2b_%0d_handshake: ok=%b done_next=%b exp 1 1", n, ok, dn); else n_pass++;
            n_checks++; if (core_mod[c*DATA_W +: DATA_W] !== m_mod[c] || core_op_a[c*DATA_W +: DATA_W] !== m_a[c] ||
                            core_op_b[c*DATA_W +: DATA_W] !== m_b[c])
                $display("FAIL b2b_%0d_regs core%0d: mod %h a %h b %h exp %h %h %h (low 32)", n, c,
                         core_mod[c*DATA_W +: 32], core_op_a[c*DATA_W +: 32], core_op_b[c*DATA_W +: 32],
                         m_mod[c][31:0], m_a[c][31:0], m_b[c][31:0]); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_rx();
        logic [DATA_W-1:0] w, r, got;
        bit ok, dn;
        do_cmd(OP_MOD, 1, 1'b0);
        arm_to_fpga_data       = rand_word();
        arm_to_fpga_data_valid = 1'b1;
        #2;
        reset = 1'b1;
        core_result = '0;
        #1;
        model_clear();
        n_checks++; if (arm_to_fpga_data_ready !== 1'b0 || fpga_to_arm_done !== 1'b0 || fpga_to_arm_data_valid !== 1'b0)
            $display("FAIL rst_handshakes: ready=%b done=%b valid=%b exp 0 0 0", arm_to_fpga_data_ready, fpga_to_arm_done, fpga_to_arm_data_valid); else n_pass++;
        n_checks++; if (leds !== 4'h0 || cmd_error !== 1'b0 || core_start !== '0 || core_mode !== '0)
            $display("FAIL rst_status: leds=%h err=%b start=%b mode=%b exp 0", leds, cmd_error, core_start, core_mode); else n_pass++;
        n_checks++; if (core_mod !== '0 || core_op_a !== '0 || core_op_b !== '0)
            $display("FAIL rst_regs: set bits %0d exp 0", $countones(core_mod) + $countones(core_op_a) + $countones(core_op_b)); else n_pass++;
        @(posedge clk);
        #3;
        reset = 1'b0;
        tick();
        arm_to_fpga_data_valid = 1'b0;
        n_checks++; if (core_mod !== '0 || arm_to_fpga_data_ready !== 1'b0) $display("FAIL rst_idle_ignores_data: set bits %0d ready %b exp 0 0", $countones(core_mod), arm_to_fpga_data_ready); else n_pass++;

        w = rand_word();
        load_reg(OP_MOD, 1, w, ok, dn);
        n_checks++; if (!(ok && dn) || core_mod[DATA_W +: DATA_W] !== m_mod[1])
            $display("FAIL rst_fresh_read_mod: ok=%b dn=%b got %h exp %h (low 64)", ok, dn, core_mod[DATA_W +: 64], m_mod[1][63:0]); else n_pass++;

        r = rand_word();
        core_result[0 +: DATA_W] = r;
        do_cmd(OP_WRITE, 0, 1'b0);
        do_tx(got, ok);
        n_checks++; if (!ok || got !== r) $display("FAIL never_launched_write: ok=%b got %h exp %h (low 64)", ok, got[63:0], r[63:0]); else n_pass++;
        wait_done(ok);
        ack_done();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset                  = 1'b1;
        arm_to_fpga_cmd        = '0;
        arm_to_fpga_cmd_valid  = 1'b0;
        fpga_to_arm_done_read  = 1'b0;
        arm_to_fpga_data_valid = 1'b0;
        arm_to_fpga_data       = '0;
        fpga_to_arm_data_ready = 1'b0;
        core_result            = '0;
        core_done              = '0;
        model_clear();
        #23;
        test_reset();
        reset = 1'b0;
        tick();
        test_mont_blocking();
        test_nowait_concurrent();
        test_illegal();
        test_write_waits();
        test_busy_start();
        test_back_to_back();
        test_reset_mid_rx();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
